// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - wide adder built by time-sharing one 4-bit adder, LS nibble first

// Plain 4-bit adder with no carry-in; result[4] is the carry out.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] result
);
  // Zero-extend both operands so the carry lands in bit 4.
  always_comb begin
    result = {1'b0, a} + {1'b0, b};
  end
endmodule

// Sequencer: one ADD pass per nibble, plus an INC pass through the same
// adder whenever a carry is pending into that nibble.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic                      carry_q;
  logic                      held_c1_q;
  logic [3:0]                partial_q;
  logic [NIBBLES-1:0][3:0]   op_a_q;
  logic [NIBBLES-1:0][3:0]   op_b_q;
  logic [NIBBLES-1:0][3:0]   sum_q;
  logic                      cout_q;
  logic                      res_valid_q;
  logic                      busy_q;
  logic                      start_ready_q;

  logic [3:0]                add_a;
  logic [3:0]                add_b;
  logic [4:0]                add_r;
  logic                      inc_carry;

  // Operand muxes for the shared adder: operand nibbles in ADD, partial+1 in INC.
  always_comb begin
    add_a = op_a_q[idx_q];
    add_b = op_b_q[idx_q];
    if (state_q == S_INC) begin
      add_a = partial_q;
      add_b = 4'b0001;
    end
  end

  four_bit_adder u_adder (
    .a      (add_a),
    .b      (add_b),
    .result (add_r)
  );

  // The two pass carries of one nibble are never both set; OR merges them.
  assign inc_carry = held_c1_q | add_r[4];

  // Main sequencer with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      held_c1_q     <= 1'b0;
      partial_q     <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid && start_ready_q) begin
            op_a_q        <= op_a;
            op_b_q        <= op_b;
            carry_q       <= cin;
            idx_q         <= '0;
            sum_q         <= '0;
            state_q       <= S_ADD;
            busy_q        <= 1'b1;
            start_ready_q <= 1'b0;
          end
        end
        S_ADD: begin
          if (carry_q) begin
            partial_q <= add_r[3:0];
            held_c1_q <= add_r[4];
            state_q   <= S_INC;
          end else begin
            sum_q[idx_q] <= add_r[3:0];
            carry_q      <= add_r[4];
            if (idx_q == LAST_IDX) begin
              cout_q      <= add_r[4];
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_ADD;
            end
          end
        end
        S_INC: begin
          sum_q[idx_q] <= add_r[3:0];
          carry_q      <= inc_carry;
          if (idx_q == LAST_IDX) begin
            cout_q      <= inc_carry;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - self-checking bench for nibble_serial_adder_ctrl

module tb_nibble_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  // Reference: exact unsigned sum.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Reference: one cycle per nibble, plus one for every nibble whose
  // incoming carry (from the lower nibbles plus cin) is set.
  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int lat;
    longint unsigned m;
    lat = NIB;
    for (int i = 0; i < NIB; i++) begin
      m = 64'd1 << (4 * i);
      if ((longint'(a) % m) + (longint'(b) % m) + longint'(c) >= m) lat++;
    end
    return lat;
  endfunction

  // Drive one operation, measure latency, capture the result, then accept it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int rdy_delay, output int lat, output logic [W-1:0] s, output logic co);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    s  = sum;
    co = cout;
    repeat (rdy_delay) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({start_ready, res_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got sr=%0b rv=%0b busy=%0b cout=%0b sum=%h, want sr=1 rv=0 busy=0 cout=0 sum=0000",
               start_ready, res_valid, busy, cout, sum);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF};
    logic [W-1:0] vb [4] = '{16'h1111, 16'h0001, 16'h0000, 16'hFFFF};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int           vl [4] = '{4, 7, 5, 8};
    logic [W:0]   vs [4] = '{17'h02345, 17'h10000, 17'h00001, 17'h1FFFF};
    int lat; logic [W-1:0] s; logic co;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], 0, lat, s, co);
      n_checks++;
      if (lat != vl[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, vl[i]);
      end
      n_checks++;
      if ({co, s} !== vs[i]) begin
        n_fail++;
        $display("FAIL directed_sum[%0d]: got cout=%0b sum=%h want %h", i, co, s, vs[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat; bit ok_hold; bit ok_sr;
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != ref_latency(16'h0F0F, 16'h0101, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want %0d", lat, ref_latency(16'h0F0F, 16'h0101, 1'b0));
    end
    ok_hold = 1; ok_sr = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        op_a = 16'hAAAA; op_b = 16'h5555; start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      if (!(res_valid === 1'b1 && sum === 16'h1010 && cout === 1'b0)) ok_hold = 0;
      if (start_ready !== 1'b0 || busy !== 1'b1) ok_sr = 0;
    end
    @(negedge clk);
    start_valid = 1'b0;
    n_checks++;
    if (!ok_hold || res_valid !== 1'b1 || sum !== 16'h1010) begin
      n_fail++;
      $display("FAIL bp_hold: got rv=%0b sum=%h cout=%0b want rv=1 sum=1010 cout=0 throughout", res_valid, sum, cout);
    end
    n_checks++;
    if (!ok_sr) begin
      n_fail++;
      $display("FAIL bp_busy_ready: got start_ready/busy not 0/1 during DONE, want 0/1");
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    n_checks++;
    if ({start_ready, res_valid, busy, sum} !== {1'b1, 1'b0, 1'b0, 16'h1010}) begin
      n_fail++;
      $display("FAIL bp_release: got sr=%0b rv=%0b busy=%0b sum=%h want sr=1 rv=0 busy=0 sum=1010",
               start_ready, res_valid, busy, sum);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [W-1:0] s; logic co;
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_running: got busy=%0b rv=%0b want busy=1 rv=0", busy, res_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({start_ready, res_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL mid_reset: got sr=%0b rv=%0b busy=%0b cout=%0b sum=%h want 1/0/0/0/0000",
               start_ready, res_valid, busy, cout, sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0001, 16'h0002, 1'b0, 0, lat, s, co);
    n_checks++;
    if (lat != 4 || {co, s} !== 17'h00003) begin
      n_fail++;
      $display("FAIL post_reset_op: got lat=%0d cout=%0b sum=%h want lat=4 cout=0 sum=0003", lat, co, s);
    end
  endtask

  task automatic test_random;
    int lat; logic [W-1:0] s; logic co;
    logic [W-1:0] a; logic [W-1:0] b; logic c;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      if (i % 8 == 0) b = ~a;
      run_op(a, b, c, int'($urandom_range(0, 3)), lat, s, co);
      n_checks++;
      if ({co, s} !== ref_sum(a, b, c)) begin
        n_fail++;
        $display("FAIL random_sum[%0d]: %h+%h+%0b got %h want %h", i, a, b, c, {co, s}, ref_sum(a, b, c));
      end
      n_checks++;
      if (lat != ref_latency(a, b, c)) begin
        n_fail++;
        $display("FAIL random_latency[%0d]: %h+%h+%0b got %0d want %0d", i, a, b, c, lat, ref_latency(a, b, c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
